// File: rtl/mips_irq_pkg.sv
// mips_irq_pkg: shared types and default constants for the MIPS interrupt
// controller.
//   irq_state_e     - controller FSM state encoding
//   DEF_VEC_BASE    - default vector of channel 0
//   DEF_VEC_STRIDE  - default byte distance between channel vectors
//   DEF_NMI_VEC     - default NMI vector
package mips_irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SVC,
    ST_NMI_REQ,
    ST_NMI_SVC
  } irq_state_e;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0080;
  localparam int          DEF_VEC_STRIDE = 8;
  localparam logic [31:0] DEF_NMI_VEC    = 32'h0000_0100;

endpackage

// File: rtl/mips_irq_prio_enc.sv
// mips_irq_prio_enc: lowest-index-first priority encoder.
//   i_req   - request vector
//   o_valid - any request set
//   o_idx   - index of the lowest set bit (0 when none)
module mips_irq_prio_enc #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i_req[i]) o_idx = IW'(i);
  end

endmodule

// File: rtl/mips_irq_controller.sv
// mips_irq_controller: vectored interrupt controller for the multi-cycle MIPS
// core. NUM_IRQ maskable channels (level or rising-edge per EDGE_MASK) plus a
// rising-edge NMI that may preempt one maskable service level.
//   clk, rst_n      - clock, asynchronous active-low reset
//   i_irq           - channel requests
//   i_nmi           - non-maskable request (rising edge)
//   i_int_disable   - global disable of maskable channels
//   i_mask_wr/wdata - enable mask write (1 = enabled)
//   i_int_ack       - core took the presented interrupt
//   i_eoi           - handler returned
//   o_int_req       - request to the core
//   o_int_is_nmi    - current request/service is the NMI
//   o_int_vector    - handler address while o_int_req = 1
//   o_active_id     - channel being requested/serviced
//   o_in_service    - a handler is running
//   o_pending       - pending register
module mips_irq_controller
  import mips_irq_pkg::*;
#(
  parameter  int                 NUM_IRQ    = 8,
  parameter  int                 VEC_W      = 32,
  parameter  logic [VEC_W-1:0]   VEC_BASE   = VEC_W'(DEF_VEC_BASE),
  parameter  int                 VEC_STRIDE = DEF_VEC_STRIDE,
  parameter  logic [VEC_W-1:0]   NMI_VEC    = VEC_W'(DEF_NMI_VEC),
  parameter  logic [NUM_IRQ-1:0] EDGE_MASK  = '0,
  localparam int                 IW         = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_nmi,
  input  logic               i_int_disable,
  input  logic               i_mask_wr,
  input  logic [NUM_IRQ-1:0] i_mask_wdata,
  input  logic               i_int_ack,
  input  logic               i_eoi,
  output logic               o_int_req,
  output logic               o_int_is_nmi,
  output logic [VEC_W-1:0]   o_int_vector,
  output logic [IW-1:0]      o_active_id,
  output logic               o_in_service,
  output logic [NUM_IRQ-1:0] o_pending
);

  irq_state_e         r_state, w_state_nxt;
  logic [IW-1:0]      r_id, w_id_nxt;
  logic               r_nested, w_nested_nxt;
  logic [NUM_IRQ-1:0] r_irq_q, r_pend, r_mask;
  logic               r_nmi_q, r_nmi_pend;
  logic               r_int_req, r_is_nmi, r_in_svc;
  logic [VEC_W-1:0]   r_vec, w_vec_nxt;

  logic [NUM_IRQ-1:0] w_elig, w_edge_set, w_ack_clr, w_pend_nxt;
  logic               w_win_vld, w_ack_req, w_ack_nmi, w_nmi_set;
  logic [IW-1:0]      w_win_id;

  assign w_elig = r_pend & r_mask & ~{NUM_IRQ{i_int_disable}};

  mips_irq_prio_enc #(.N(NUM_IRQ)) u_prio (
    .i_req   (w_elig),
    .o_valid (w_win_vld),
    .o_idx   (w_win_id)
  );

  // Acks only count in the matching request state.
  assign w_ack_req  = i_int_ack && (r_state == ST_REQ);
  assign w_ack_nmi  = i_int_ack && (r_state == ST_NMI_REQ);
  assign w_edge_set = i_irq & ~r_irq_q;
  assign w_ack_clr  = w_ack_req ? (NUM_IRQ'(1) << r_id) : '0;
  // Edge channels: a fresh edge wins over the ack clear. Level channels
  // simply follow the sampled input.
  assign w_pend_nxt = (EDGE_MASK & (w_edge_set | (r_pend & ~w_ack_clr))) |
                      (~EDGE_MASK & i_irq);
  assign w_nmi_set  = i_nmi & ~r_nmi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_q    <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
      r_nmi_q    <= 1'b0;
      r_nmi_pend <= 1'b0;
    end else begin
      r_irq_q    <= i_irq;
      r_pend     <= w_pend_nxt;
      r_nmi_q    <= i_nmi;
      r_nmi_pend <= w_nmi_set | (r_nmi_pend & ~w_ack_nmi);
      if (i_mask_wr) r_mask <= i_mask_wdata;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_id_nxt     = r_id;
    w_nested_nxt = r_nested;
    case (r_state)
      ST_IDLE:
        if (r_nmi_pend) w_state_nxt = ST_NMI_REQ;
        else if (w_win_vld) begin
          w_state_nxt = ST_REQ;
          w_id_nxt    = w_win_id;
        end
      // An ack in the same cycle as an NMI wins: the core saw the maskable
      // request, and the NMI then preempts its service as a nested level.
      ST_REQ:
        if (i_int_ack) w_state_nxt = ST_SVC;
        else if (r_nmi_pend) w_state_nxt = ST_NMI_REQ;
      ST_SVC:
        if (i_eoi) w_state_nxt = ST_IDLE;
        else if (r_nmi_pend) begin
          w_state_nxt  = ST_NMI_REQ;
          w_nested_nxt = 1'b1;
        end
      ST_NMI_REQ:
        if (i_int_ack) w_state_nxt = ST_NMI_SVC;
      ST_NMI_SVC:
        if (i_eoi) begin
          w_state_nxt  = r_nested ? ST_SVC : ST_IDLE;
          w_nested_nxt = 1'b0;
        end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_vec_nxt = '0;
    if (w_state_nxt inside {ST_NMI_REQ, ST_NMI_SVC})
      w_vec_nxt = NMI_VEC;
    else if (w_state_nxt == ST_REQ)
      w_vec_nxt = VEC_BASE + VEC_W'(w_id_nxt) * VEC_W'(VEC_STRIDE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_id      <= '0;
      r_nested  <= 1'b0;
      r_int_req <= 1'b0;
      r_is_nmi  <= 1'b0;
      r_in_svc  <= 1'b0;
      r_vec     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_id      <= w_id_nxt;
      r_nested  <= w_nested_nxt;
      r_int_req <= w_state_nxt inside {ST_REQ, ST_NMI_REQ};
      r_is_nmi  <= w_state_nxt inside {ST_NMI_REQ, ST_NMI_SVC};
      r_in_svc  <= w_state_nxt inside {ST_SVC, ST_NMI_SVC};
      r_vec     <= w_vec_nxt;
    end
  end

  assign o_int_req    = r_int_req;
  assign o_int_is_nmi = r_is_nmi;
  assign o_in_service = r_in_svc;
  assign o_int_vector = r_vec;
  assign o_active_id  = r_id;
  assign o_pending    = r_pend;

endmodule

// File: tb/tb_mips_irq_controller.sv
// tb_mips_irq_controller: directed scenarios followed by a random phase, every
// cycle checked against a behavioural model of the controller.
module tb_mips_irq_controller;

  localparam logic [7:0] EDGE = 8'h02;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq = '0;
  logic       nmi = 1'b0, dis = 1'b0, mwr = 1'b0, ack = 1'b0, eoi = 1'b0;
  logic [7:0] mwd = '0;

  logic        o_int_req, o_int_is_nmi, o_in_service;
  logic [31:0] o_int_vector;
  logic [2:0]  o_active_id;
  logic [7:0]  o_pending;

  int n_cmp = 0;
  int n_bad = 0;

  mips_irq_controller #(.NUM_IRQ(8), .VEC_W(32), .EDGE_MASK(EDGE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_irq        (irq),
    .i_nmi        (nmi),
    .i_int_disable(dis),
    .i_mask_wr    (mwr),
    .i_mask_wdata (mwd),
    .i_int_ack    (ack),
    .i_eoi        (eoi),
    .o_int_req    (o_int_req),
    .o_int_is_nmi (o_int_is_nmi),
    .o_int_vector (o_int_vector),
    .o_active_id  (o_active_id),
    .o_in_service (o_in_service),
    .o_pending    (o_pending)
  );

  always #5 clk = ~clk;

  // Reference model: what the controller is doing, as flags.
  bit       m_req_mask;   // maskable request presented
  bit       m_svc_mask;   // maskable handler running
  bit       m_req_nmi;    // NMI request presented
  bit       m_svc_nmi;    // NMI handler running
  bit       m_nested;     // a maskable service is suspended under the NMI
  int       m_id;
  bit [7:0] m_pend, m_mask, m_irq_prev;
  bit       m_nmi_pend, m_nmi_prev;

  task automatic model_reset();
    m_req_mask = 0; m_svc_mask = 0; m_req_nmi = 0; m_svc_nmi = 0;
    m_nested = 0; m_id = 0; m_pend = '0; m_mask = '0; m_irq_prev = '0;
    m_nmi_pend = 0; m_nmi_prev = 0;
  endtask

  task automatic model_tick();
    bit [7:0] elig, np;
    int win;
    bit idle, nnp;
    elig = m_pend & m_mask & (dis ? 8'h00 : 8'hFF);
    win = -1;
    for (int i = 0; i < 8; i++) if (elig[i] && win < 0) win = i;
    for (int i = 0; i < 8; i++) begin
      if (EDGE[i]) begin
        if (irq[i] && !m_irq_prev[i]) np[i] = 1'b1;
        else if (m_req_mask && ack && m_id == i) np[i] = 1'b0;
        else np[i] = m_pend[i];
      end else np[i] = irq[i];
    end
    nnp = (nmi && !m_nmi_prev) || (m_nmi_pend && !(m_req_nmi && ack));
    idle = !(m_req_mask || m_svc_mask || m_req_nmi || m_svc_nmi);
    if (idle) begin
      if (m_nmi_pend) m_req_nmi = 1;
      else if (win >= 0) begin m_req_mask = 1; m_id = win; end
    end else if (m_req_mask) begin
      if (ack) begin m_req_mask = 0; m_svc_mask = 1; end
      else if (m_nmi_pend) begin m_req_mask = 0; m_req_nmi = 1; end
    end else if (m_svc_mask) begin
      if (eoi) m_svc_mask = 0;
      else if (m_nmi_pend) begin m_svc_mask = 0; m_nested = 1; m_req_nmi = 1; end
    end else if (m_req_nmi) begin
      if (ack) begin m_req_nmi = 0; m_svc_nmi = 1; end
    end else if (m_svc_nmi && eoi) begin
      m_svc_nmi = 0;
      m_svc_mask = m_nested;
      m_nested = 0;
    end
    m_pend = np;
    m_nmi_pend = nnp;
    m_irq_prev = irq;
    m_nmi_prev = nmi;
    if (mwr) m_mask = mwd;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] ev;
    ev = (m_req_nmi || m_svc_nmi) ? 32'h100 : m_req_mask ? 32'h80 + 8 * m_id : 32'h0;
    chk("int_req", {31'b0, o_int_req}, {31'b0, m_req_mask || m_req_nmi});
    chk("int_is_nmi", {31'b0, o_int_is_nmi}, {31'b0, m_req_nmi || m_svc_nmi});
    chk("in_service", {31'b0, o_in_service}, {31'b0, m_svc_mask || m_svc_nmi});
    chk("int_vector", o_int_vector, ev);
    chk("active_id", {29'b0, o_active_id}, m_id);
    chk("pending", {24'b0, o_pending}, {24'b0, m_pend});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_tick(); else model_reset();
    #1;
    check_all();
  endtask

  task automatic pulse_ack(); ack = 1; tick(); ack = 0; endtask
  task automatic pulse_eoi(); eoi = 1; tick(); eoi = 0; endtask

  initial begin
    model_reset();
    #1 check_all();
    tick(); tick();
    rst_n = 1;

    // mask all on, level channel 3
    mwr = 1; mwd = 8'hFF; tick(); mwr = 0;
    irq = 8'h08; tick();
    chk("lat_no_req_yet", {31'b0, o_int_req}, 32'd0);
    tick();
    chk("t1_req", {31'b0, o_int_req}, 32'd1);
    chk("t1_id", {29'b0, o_active_id}, 32'd3);
    chk("t1_vec", o_int_vector, 32'h98);
    pulse_ack();
    chk("t1_svc", {31'b0, o_in_service}, 32'd1);
    irq = 8'h00; tick();
    pulse_eoi();
    chk("t1_eoi", {31'b0, o_in_service}, 32'd0);

    // two channels at once: 2 then 5
    irq = 8'h24; tick(); tick();
    chk("t2_id2", {29'b0, o_active_id}, 32'd2);
    pulse_ack();
    irq = 8'h20; tick();
    pulse_eoi();
    tick();
    chk("t2_id5", {29'b0, o_active_id}, 32'd5);
    chk("t2_vec5", o_int_vector, 32'hA8);
    pulse_ack();
    irq = 8'h00; tick();
    pulse_eoi();

    // edge channel 1 pulse while disabled
    dis = 1; irq = 8'h02; tick(); irq = 8'h00;
    chk("t3_pend1", {31'b0, o_pending[1]}, 32'd1);
    tick(); tick(); tick();
    chk("t3_noreq", {31'b0, o_int_req}, 32'd0);
    dis = 0; tick();
    chk("t3_req1", {29'b0, o_active_id}, 32'd1);
    pulse_ack(); pulse_eoi();

    // NMI nested over service of channel 4
    irq = 8'h10; tick(); tick(); pulse_ack();
    nmi = 1; tick(); nmi = 0; tick();
    chk("t4_nmi_req", {31'b0, o_int_is_nmi & o_int_req}, 32'd1);
    chk("t4_nmi_vec", o_int_vector, 32'h100);
    pulse_ack(); pulse_eoi();
    chk("t4_back_id", {29'b0, o_active_id}, 32'd4);
    chk("t4_back_svc", {31'b0, o_in_service & ~o_int_is_nmi}, 32'd1);
    irq = 8'h00; tick(); pulse_eoi();

    // edge rises on the channel being acked
    irq = 8'h02; tick(); irq = 8'h00; tick();
    irq = 8'h02; ack = 1; tick(); ack = 0; irq = 8'h00;
    chk("t5_pend_kept", {31'b0, o_pending[1]}, 32'd1);
    pulse_eoi(); tick();
    chk("t5_rereq", {31'b0, o_int_req}, 32'd1);
    pulse_ack(); pulse_eoi();

    // async reset during NMI service
    nmi = 1; tick(); nmi = 0; tick(); pulse_ack();
    chk("t6_nmi_svc", {31'b0, o_in_service & o_int_is_nmi}, 32'd1);
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    tick(); rst_n = 1;
    irq = 8'hFF; tick(); tick(); tick();
    chk("t6_mask_zero", {31'b0, o_int_req}, 32'd0);
    irq = 8'h00; tick();

    // random phase
    for (int c = 0; c < 3000; c++) begin
      irq = 8'($urandom) & 8'($urandom);
      nmi = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 40) == 0) dis = ~dis;
      ack = ($urandom_range(0, 3) == 0);
      eoi = ($urandom_range(0, 4) == 0);
      mwr = ($urandom_range(0, 20) == 0);
      mwd = 8'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
